// File: rtl/jtcps1_gfx_pkg.sv
// Shared definitions for the CPS1 GFX requester: layer codes, FSM state encodings
// and the blank pixel word returned for unmapped tiles.
package jtcps1_gfx_pkg;

  typedef enum logic [2:0] {
    LAYER_OBJ   = 3'd0,
    LAYER_SCR1  = 3'd1,
    LAYER_SCR2  = 3'd2,
    LAYER_SCR3  = 3'd3,
    LAYER_STARS = 3'd4
  } gfx_layer_e;

  // FSM states kept as plain constants so older tools and netlists see fixed codes
  typedef logic [1:0] gfx_state_t;
  localparam gfx_state_t ST_IDLE = 2'd0;
  localparam gfx_state_t ST_MAP  = 2'd1;
  localparam gfx_state_t ST_ROM  = 2'd2;
  localparam gfx_state_t ST_DONE = 2'd3;

  localparam logic [31:0] GFX_BLANK = 32'hFFFF_FFFF;

endpackage

// File: rtl/jtcps1_gfx_addr_req.sv
// Requester side of the CPS1 GFX bank mapper: takes one tile fetch at a time, waits for
// the mapper, builds the ROM word address and runs the SDRAM handshake.
module jtcps1_gfx_addr_req
  import jtcps1_gfx_pkg::*;
#(
  parameter int          SUB_W   = 6,
  parameter int          MAP_LAT = 2,
  parameter logic [31:0] BLANK   = GFX_BLANK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [2:0]          layer,
  input  logic [15:0]         code,
  input  logic [SUB_W-1:0]    sub,
  output logic                busy,
  output logic                ok,
  output logic [31:0]         data,
  output logic                map_enable,
  output logic [2:0]          map_layer,
  output logic [9:0]          map_cin,
  input  logic [3:0]          map_offset,
  input  logic [3:0]          map_mask,
  input  logic                map_unmapped,
  output logic [16+SUB_W-1:0] rom_addr,
  output logic                rom_cs,
  input  logic                rom_ok,
  input  logic [31:0]         rom_data
);

  localparam int CNT_W = $clog2(MAP_LAT + 1);

  gfx_state_t          state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [15:0]         code_q,       code_d;
  logic [SUB_W-1:0]    sub_q,        sub_d;
  logic                rom_first_q,  rom_first_d;
  logic                busy_q,       busy_d;
  logic                ok_q,         ok_d;
  logic [31:0]         data_q,       data_d;
  logic                map_enable_q, map_enable_d;
  logic [2:0]          map_layer_q,  map_layer_d;
  logic [9:0]          map_cin_q,    map_cin_d;
  logic [16+SUB_W-1:0] rom_addr_q,   rom_addr_d;
  logic                rom_cs_q,     rom_cs_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    sub_d       = sub_q;
    rom_first_d = 1'b0;
    data_d      = data_q;
    map_layer_d = map_layer_q;
    map_cin_d   = map_cin_q;
    rom_addr_d  = rom_addr_q;
    rom_cs_d    = rom_cs_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          code_d      = code;
          sub_d       = sub;
          map_layer_d = layer;
          map_cin_d   = code[15:6];
          cnt_d       = '0;
          state_d     = ST_MAP;
        end
      end
      ST_MAP: begin
        // cnt counts cycles since map_cin became valid; the result is usable once it hits MAP_LAT
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MAP_LAT)) begin
          if (map_unmapped) begin
            data_d  = BLANK;
            state_d = ST_DONE;
          end else begin
            rom_addr_d  = {(code_q[15:12] & map_mask) | map_offset, code_q[11:0], sub_q};
            rom_cs_d    = 1'b1;
            rom_first_d = 1'b1;
            state_d     = ST_ROM;
          end
        end
      end
      ST_ROM: begin
        // rom_ok in the first cycle can belong to the previous SDRAM client
        if (!rom_first_q && rom_ok) begin
          data_d   = rom_data;
          rom_cs_d = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    ok_d         = (state_d == ST_DONE);
    map_enable_d = (state_d == ST_MAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      code_q       <= '0;
      sub_q        <= '0;
      rom_first_q  <= 1'b0;
      busy_q       <= 1'b0;
      ok_q         <= 1'b0;
      data_q       <= '0;
      map_enable_q <= 1'b0;
      map_layer_q  <= '0;
      map_cin_q    <= '0;
      rom_addr_q   <= '0;
      rom_cs_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      sub_q        <= sub_d;
      rom_first_q  <= rom_first_d;
      busy_q       <= busy_d;
      ok_q         <= ok_d;
      data_q       <= data_d;
      map_enable_q <= map_enable_d;
      map_layer_q  <= map_layer_d;
      map_cin_q    <= map_cin_d;
      rom_addr_q   <= rom_addr_d;
      rom_cs_q     <= rom_cs_d;
    end
  end

  assign busy       = busy_q;
  assign ok         = ok_q;
  assign data       = data_q;
  assign map_enable = map_enable_q;
  assign map_layer  = map_layer_q;
  assign map_cin    = map_cin_q;
  assign rom_addr   = rom_addr_q;
  assign rom_cs     = rom_cs_q;

endmodule

// File: tb/tb_jtcps1_gfx_addr_req.sv
// Randomized bench for jtcps1_gfx_addr_req with a registered mapper model (two stages)
// and an SDRAM model whose ok delay and stale-ok behaviour are set per transaction.
module tb_jtcps1_gfx_addr_req;

  localparam int SUB_W   = 6;
  localparam int MAP_LAT = 2;
  localparam int BUDGET  = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic [2:0]        layer = '0;
  logic [15:0]       code = '0;
  logic [SUB_W-1:0]  sub = '0;
  logic              busy, ok, map_enable, rom_cs, rom_ok, map_unmapped;
  logic [31:0]       data, rom_data;
  logic [2:0]        map_layer;
  logic [9:0]        map_cin;
  logic [3:0]        map_offset, map_mask;
  logic [16+SUB_W-1:0] rom_addr;

  int checks = 0;
  int errors = 0;

  // Mapper model: lookup on {layer, code[15:12]} followed by two pipeline registers
  logic [8:0] lut [0:127];
  logic [8:0] map_p1, map_p2;
  always @(posedge clk) begin
    map_p1 <= lut[{map_layer, map_cin[9:6]}];
    map_p2 <= map_p1;
  end
  assign map_unmapped = map_p2[8];
  assign map_mask     = map_p2[7:4];
  assign map_offset   = map_p2[3:0];

  // SDRAM model: data = base + cycles since cs rose, ok after a programmable delay
  int          rom_dly = 0;
  logic        rom_stale = 1'b0;
  logic [31:0] rom_base = '0;
  int          rom_age = 0;
  always @(posedge clk) begin
    if (!rom_cs) rom_age <= 0;
    else         rom_age <= rom_age + 1;
  end
  assign rom_ok   = rom_stale || (rom_cs && (rom_age >= rom_dly));
  assign rom_data = rom_base + 32'(rom_age);

  jtcps1_gfx_addr_req #(.SUB_W(SUB_W), .MAP_LAT(MAP_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .layer(layer), .code(code), .sub(sub),
    .busy(busy), .ok(ok), .data(data), .map_enable(map_enable), .map_layer(map_layer),
    .map_cin(map_cin), .map_offset(map_offset), .map_mask(map_mask),
    .map_unmapped(map_unmapped), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_ok(rom_ok), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after ok
  task automatic applyStimulus(input logic [2:0] lay, input logic [15:0] cd, input logic [SUB_W-1:0] sb,
                               input logic [3:0] off, input logic [3:0] msk, input logic unm,
                               input int dly, input logic stl, input logic hold_req);
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          cap, exp_lat, n;
    logic        cs_seen, done;
    exp_addr  = ((((32'(cd) >> 12) & 32'(msk)) | 32'(off)) << 18) + ((32'(cd) % 4096) * 64) + 32'(sb);
    cap       = stl ? 1 : ((dly < 1) ? 1 : dly);
    rom_base  = $urandom;
    exp_data  = unm ? 32'hFFFF_FFFF : rom_base + 32'(cap);
    exp_lat   = unm ? MAP_LAT + 2 : MAP_LAT + 2 + cap + 1;
    lut[{lay, cd[15:12]}] = {unm, msk, off};
    rom_dly   = dly;
    rom_stale = stl;
    layer = lay; code = cd; sub = sb; req = 1'b1;
    checkOutput("idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    cs_seen = 1'b0;
    done    = 1'b0;
    for (n = 1; n <= BUDGET && !done; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (!hold_req) req = 1'b0;
        checkOutput("map_cin", 64'(map_cin), 64'(cd[15:6]));
        checkOutput("map_layer", 64'(map_layer), 64'(lay));
        checkOutput("map_enable", 64'(map_enable), 64'd1);
      end
      checkOutput("busy_inflight", 64'(busy), 64'd1);
      if (rom_cs) begin
        if (!cs_seen) checkOutput("cs_rise_time", 64'(n), 64'(MAP_LAT + 2));
        cs_seen = 1'b1;
        checkOutput("rom_addr", 64'(rom_addr), 64'(exp_addr));
      end
      if (ok) begin
        done = 1'b1;
        checkOutput("ok_latency", 64'(n), 64'(exp_lat));
        checkOutput("data", 64'(data), 64'(exp_data));
        checkOutput("cs_low_at_ok", 64'(rom_cs), 64'd0);
      end
    end
    if (!done) checkOutput("ok_timeout", 64'd0, 64'd1);
    checkOutput("cs_seen", 64'(cs_seen), 64'(!unm));
    @(negedge clk);
    checkOutput("ok_one_cycle", 64'(ok), 64'd0);
    checkOutput("busy_after_ok", 64'(busy), 64'd0);
    checkOutput("data_hold", 64'(data), 64'(exp_data));
  endtask

  initial begin
    logic [3:0] r_off, r_msk;
    for (int i = 0; i < 128; i++) lut[i] = 9'h100;

    #12;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ok", 64'(ok), 64'd0);
    checkOutput("rst_data", 64'(data), 64'd0);
    checkOutput("rst_rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("rst_rom_cs", 64'(rom_cs), 64'd0);
    checkOutput("rst_map_cin", 64'(map_cin), 64'd0);
    checkOutput("rst_map_layer", 64'(map_layer), 64'd0);
    checkOutput("rst_map_enable", 64'(map_enable), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] pass-through, banked, unmapped, stale ok");
    applyStimulus(3'd1, 16'h1234, 6'h05, 4'h0, 4'hF, 1'b0, 3, 1'b0, 1'b0);
    applyStimulus(3'd2, 16'hF00A, 6'h00, 4'h8, 4'h3, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus(3'd0, 16'h7777, 6'h3F, 4'h0, 4'hF, 1'b1, 1, 1'b0, 1'b0);
    applyStimulus(3'd3, 16'hABCD, 6'h11, 4'h2, 4'hC, 1'b0, 0, 1'b1, 1'b0);
    rom_stale = 1'b0;

    $display("[TB] back-to-back with req held high");
    applyStimulus(3'd4, 16'h5A5A, 6'h2A, 4'h1, 4'h7, 1'b0, 1, 1'b0, 1'b1);
    applyStimulus(3'd1, 16'hC3C3, 6'h15, 4'h4, 4'hA, 1'b1, 0, 1'b0, 1'b1);
    applyStimulus(3'd2, 16'h0FF0, 6'h01, 4'h0, 4'hF, 1'b0, 4, 1'b0, 1'b0);

    $display("[TB] reset during ROM phase");
    lut[{3'd1, 4'h9}] = {1'b0, 4'hF, 4'h0};
    rom_dly = 6;
    layer = 3'd1; code = 16'h9876; sub = 6'h02; req = 1'b1;
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < 20 && !rom_cs; i++) @(negedge clk);
    checkOutput("rst_mid_cs_up", 64'(rom_cs), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_cs", 64'(rom_cs), 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_ok", 64'(ok), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(3'd1, 16'h9876, 6'h02, 4'h0, 4'hF, 1'b0, 2, 1'b0, 1'b0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 30; t++) begin
      r_off = 4'($urandom);
      r_msk = 4'($urandom);
      applyStimulus(3'($urandom_range(0, 4)), 16'($urandom), 6'($urandom), r_off, r_msk,
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 4),
                    ($urandom_range(0, 4) == 0), 1'($urandom));
    end
    req = 1'b0;
    rom_stale = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
